sum_16bit: RTL and testbench

//  16-bit registered carry-look-ahead (CLA) adder: sum = a + b + cin, with carry out.

---
 rtl/sum16_pkg.sv | 19 +
 rtl/cla_4bit.sv | 75 +++++++
 rtl/sum_16bit.sv | 99 +++++++++
 tb/tb_sum_16bit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/sum16_pkg.sv
// rtl/sum16_pkg.sv - shared constants and types for the 16-bit CLA adder
// Contents:
//   WIDTH, GROUP, NGROUPS  operand width, look-ahead group size, group count
//   word_t                 operand/result word
//   gp_t                   generate/propagate pair (bit level or group level)
package sum16_pkg;

    localparam int WIDTH   = 16;
    localparam int GROUP   = 4;
    localparam int NGROUPS = WIDTH / GROUP;

    typedef logic [WIDTH-1:0] word_t;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage

// File: rtl/cla_4bit.sv
// rtl/cla_4bit.sv - 4-bit carry-look-ahead slice with group generate/propagate
// Purpose: adds two 4-bit slices with a carry in, all internal carries in
//   flattened look-ahead form, and exports group G/P for the next level.
// Ports:
//   a, b  in   4  operand slices
//   ci    in   1  carry into bit 0 of the slice
//   s     out  4  slice sum
//   g     out  1  group generate  (slice produces a carry regardless of ci)
//   p     out  1  group propagate (slice passes ci straight through)
module cla_4bit
    import sum16_pkg::*;
(
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             g,
    output logic             p
);

    gp_t [GROUP-1:0]  bit_gp;
    logic [GROUP-1:0] c;

    always_comb begin
        for (int i = 0; i < GROUP; i++) begin
            bit_gp[i].g = a[i] & b[i];
            bit_gp[i].p = a[i] ^ b[i];
        end
    end

    // Each carry is a sum of products over the lower bits; no carry
    // depends on another carry, so the slice has no internal ripple.
    always_comb begin
        logic term;
        c    = '0;
        term = 1'b0;
        c[0] = ci;
        for (int k = 1; k < GROUP; k++) begin
            term = ci;
            for (int j = 0; j < k; j++) begin
                term = term & bit_gp[j].p;
            end
            c[k] = term;
            for (int j = 0; j < k; j++) begin
                term = bit_gp[j].g;
                for (int m = j + 1; m < k; m++) begin
                    term = term & bit_gp[m].p;
                end
                c[k] = c[k] | term;
            end
        end
    end

    always_comb begin
        logic term;
        g    = 1'b0;
        p    = 1'b1;
        term = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            p    = p & bit_gp[j].p;
            term = bit_gp[j].g;
            for (int m = j + 1; m < GROUP; m++) begin
                term = term & bit_gp[m].p;
            end
            g = g | term;
        end
    end

    always_comb begin
        for (int i = 0; i < GROUP; i++) begin
            s[i] = bit_gp[i].p ^ c[i];
        end
    end

endmodule

// File: rtl/sum_16bit.sv
// rtl/sum_16bit.sv - registered two-level carry-look-ahead adder
// Purpose: {cout,sum} = a + b + cin, registered one cycle after the operands.
//   4-bit CLA slices feed a group look-ahead unit; group carries are formed
//   directly from group G/P and cin, never rippled between groups.
// Optional feature: define SUM16_OVF_EN to add the registered signed
//   overflow output ovf.
// Ports:
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      synchronous active-low reset, clears all outputs
//   a, b   in   WIDTH  operands
//   cin    in   1      carry in
//   sum    out  WIDTH  registered (a + b + cin) mod 2^WIDTH
//   cout   out  1      registered carry out of the MSB
//   ovf    out  1      registered signed overflow (SUM16_OVF_EN only)
module sum_16bit
    import sum16_pkg::*;
#(
    parameter int WIDTH = sum16_pkg::WIDTH
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SUM16_OVF_EN
    ,
    output logic             ovf
`endif
);

    // WIDTH must be a multiple of GROUP.
    localparam int NG = WIDTH / GROUP;

    logic [NG:0]      gc;        // gc[k] = carry into group k, gc[NG] = cout
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [WIDTH-1:0] sum_next;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_4bit u_cla (
            .a  (a[k*GROUP +: GROUP]),
            .b  (b[k*GROUP +: GROUP]),
            .ci (gc[k]),
            .s  (sum_next[k*GROUP +: GROUP]),
            .g  (grp_g[k]),
            .p  (grp_p[k])
        );
    end

    // Group look-ahead: gc[k+1] = G[k] | P[k]G[k-1] | ... | P[k]..P[0]cin,
    // expanded fully so every group carry is two logic levels from G/P.
    always_comb begin
        logic c;
        logic term;
        gc    = '0;
        c     = 1'b0;
        term  = 1'b0;
        gc[0] = cin;
        for (int k = 0; k < NG; k++) begin
            c = cin;
            for (int j = 0; j <= k; j++) begin
                c = c & grp_p[j];
            end
            for (int j = 0; j <= k; j++) begin
                term = grp_g[j];
                for (int m = j + 1; m <= k; m++) begin
                    term = term & grp_p[m];
                end
                c = c | term;
            end
            gc[k+1] = c;
        end
    end

`ifdef SUM16_OVF_EN
    // Like-signed operands whose result sign differs: equivalent to c15 ^ c16.
    logic ovf_next;
    assign ovf_next = (a[WIDTH-1] == b[WIDTH-1]) & (sum_next[WIDTH-1] != a[WIDTH-1]);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
`ifdef SUM16_OVF_EN
            ovf  <= 1'b0;
`endif
        end else begin
            sum  <= sum_next;
            cout <= gc[NG];
`ifdef SUM16_OVF_EN
            ovf  <= ovf_next;
`endif
        end
    end

endmodule

// File: tb/tb_sum_16bit.sv
// tb/tb_sum_16bit.sv - self-checking bench for sum_16bit
module tb_sum_16bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic [15:0] sum;
    logic        cout;
`ifdef SUM16_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
    bit          have_exp = 0;

    sum_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
`ifdef SUM16_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb,
                         input logic mc, input logic mr);
        int u;
        int s;
        int sa;
        int sb;
        if (!mr) begin
            exp_sum  = 16'h0;
            exp_cout = 1'b0;
            exp_ovf  = 1'b0;
        end else begin
            u  = int'(ma) + int'(mb) + int'(mc);
            sa = int'($signed(ma));
            sb = int'($signed(mb));
            s  = sa + sb + int'(mc);
            exp_sum  = u[15:0];
            exp_cout = (u >= 65536);
            exp_ovf  = (s > 32767) || (s < -32768);
        end
    endtask

    // One cycle: drive at negedge, confirm outputs hold, check after posedge.
    task automatic step(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic tr, input string tag);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        cin   = tc;
        rst_n = tr;
        #1;
        if (have_exp) begin
            chk({tag, " hold sum"},  32'(sum),  32'(exp_sum));
            chk({tag, " hold cout"}, 32'(cout), 32'(exp_cout));
        end
        @(posedge clk);
        #1;
        model(ta, tb_v, tc, tr);
        have_exp = 1;
        chk({tag, " sum"},  32'(sum),  32'(exp_sum));
        chk({tag, " cout"}, 32'(cout), 32'(exp_cout));
`ifdef SUM16_OVF_EN
        chk({tag, " ovf"},  32'(ovf),  32'(exp_ovf));
`endif
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rr;

        step(16'h1234, 16'h1111, 1'b0, 1'b0, "reset");
        step(16'h1234, 16'h1111, 1'b1, 1'b0, "reset2");

        step(16'd1,    16'd1,    1'b0, 1'b1, "1+1");
        chk("1+1 value", 32'(sum), 32'd2);
        step(16'd20,   16'd32,   1'b0, 1'b1, "20+32");
        chk("20+32 value", 32'(sum), 32'd52);
        step(16'd200,  16'd50,   1'b1, 1'b1, "200+50+1");
        chk("200+50+1 value", 32'(sum), 32'd251);
        step(16'd76,   16'd20,   1'b0, 1'b1, "76+20");
        chk("76+20 value", 32'(sum), 32'd96);
        step(16'd562,  16'd364,  1'b0, 1'b1, "562+364");
        chk("562+364 value", 32'(sum), 32'd926);

        step(16'hFFFF, 16'h0001, 1'b0, 1'b1, "wrap");
        chk("wrap value", 32'({cout, sum}), 32'h1_0000);
        step(16'h0FFF, 16'h0001, 1'b0, 1'b1, "grp12");
        chk("grp12 value", 32'({cout, sum}), 32'h0_1000);
        step(16'h00FF, 16'h0001, 1'b0, 1'b1, "grp8");
        chk("grp8 value", 32'({cout, sum}), 32'h0_0100);
        step(16'h000F, 16'h0000, 1'b1, 1'b1, "grp4 cin");
        chk("grp4 cin value", 32'({cout, sum}), 32'h0_0010);
        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, "full");
        chk("full value", 32'({cout, sum}), 32'h1_FFFF);
        step(16'hFFFF, 16'h0000, 1'b1, 1'b1, "cin ripple");
        chk("cin ripple value", 32'({cout, sum}), 32'h1_0000);
        step(16'd30000, 16'd30000, 1'b0, 1'b1, "ovf pos");
        chk("ovf pos value", 32'({cout, sum}), 32'h0_EA60);
        step(16'h8000, 16'h8000, 1'b0, 1'b1, "ovf neg");
        chk("ovf neg value", 32'({cout, sum}), 32'h1_0000);

        // Back-to-back random operands with a reset pulse in the middle.
        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            rr = !(i >= 5000 && i < 5002);
            step(ra, rb, rc, rr, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
